// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit arbiter.
//   UART_DATA_W      - bits per UART character
//   uart_tx_state_e  - serializer FSM states
//   rr_pick()        - round-robin search; returns the first valid index at or
//                      after a pointer, wrapping modulo the requester count
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // rr_pick works on a fixed-width view so it can serve any NUM_REQ <= 32.
  localparam int RR_MAX_REQ = 32;
  localparam int RR_IDX_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                       input logic [RR_IDX_W-1:0]   ptr,
                                       input int                    num);
    rr_pick_t res;
    int       j;
    res = '0;
    // Walk offsets from farthest to nearest so the nearest valid one wins.
    for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
      if (k < num) begin
        j = int'(ptr) + k;
        if (j >= num) j = j - num;
        if (valid[j]) begin
          res.found = 1'b1;
          res.idx   = RR_IDX_W'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte-stream request bundle shared by NUM_REQ requesters.
//   req_valid [NUM_REQ]    per-requester byte valid
//   req_data  [NUM_REQ*8]  packed bytes; requester i uses bits [8i+7:8i]
//   req_last  [NUM_REQ]    byte closes its message
//   req_ready [NUM_REQ]    one-hot-or-zero accept strobe from the arbiter
// Modports: master = requester side, slave = arbiter side.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*UART_DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;

  modport master (output req_valid, output req_data, output req_last, input  req_ready);
  modport slave  (input  req_valid, input  req_data, input  req_last, output req_ready);

endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 frame generator, CLK_SAMPLES clocks per bit.
//   clk, rst  clock and synchronous active-high reset
//   load      accept data this cycle (only honoured while idle)
//   data      byte to send, LSB first
//   tx        registered serial line, idles high
//   busy      high while a start, data or stop bit is on the line
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_SAMPLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [UART_DATA_W-1:0] data,
  output logic                   tx,
  output logic                   busy
);

  localparam int                SCNT_W    = (CLK_SAMPLES > 1) ? $clog2(CLK_SAMPLES) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(CLK_SAMPLES - 1);

  uart_tx_state_e         state_q, state_d;
  logic [SCNT_W-1:0]      scnt_q, scnt_d;
  logic [2:0]             bcnt_q, bcnt_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic                   tx_q, tx_d;
  logic                   bit_end;

  assign bit_end = (scnt_q == SCNT_LAST);
  assign tx      = tx_q;
  assign busy    = (state_q != IDLE);

  // tx_d is computed from the next state so the line changes on the same edge
  // as the state, keeping tx a clean register output.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = START;
          scnt_d  = '0;
          shreg_d = data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          scnt_d  = '0;
          bcnt_d  = '0;
          tx_d    = shreg_q[0];
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          scnt_d = '0;
          if (bcnt_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bcnt_d  = bcnt_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      tx_q    <= tx_d;
    end
  end

  // Shift register is pure datapath; it is always reloaded before use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-granular sharing of one UART tx line.
//   clk, rst   clock and synchronous active-high reset
//   req        uart_tx_arbiter_if.slave request bundle (valid/data/last/ready)
//   tx         serial line, 8N1, idles high
//   busy       a frame is being shifted
//   grant_idx  current or last grantee
//   locked     a message is in progress; only grant_idx may send
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ     = 2,
  parameter  int CLK_SAMPLES = 4,
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  req,
  output logic              tx,
  output logic              busy,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              locked
);

  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic                   locked_q, locked_d;
  logic [RR_MAX_REQ-1:0]  vld_ext;
  rr_pick_t               pick;
  logic [IDX_W-1:0]       sel;
  logic                   sel_ok;
  logic                   sel_last;
  logic [UART_DATA_W-1:0] sel_data;
  logic                   hs;
  logic [NUM_REQ-1:0]     ready;

  assign grant_idx     = grant_q;
  assign locked        = locked_q;
  assign req.req_ready = ready;

  always_comb begin
    vld_ext                = '0;
    vld_ext[NUM_REQ-1:0]   = req.req_valid;
    pick                   = rr_pick(vld_ext, RR_IDX_W'(rr_ptr_q), NUM_REQ);

    // While a message is open, the holder is the only candidate, even if it
    // has paused its valid; everyone else waits.
    if (locked_q) begin
      sel    = grant_q;
      sel_ok = req.req_valid[grant_q];
    end else begin
      sel    = IDX_W'(pick.idx);
      sel_ok = pick.found;
    end

    sel_data = req.req_data[{sel, 3'b000} +: UART_DATA_W];
    sel_last = req.req_last[sel];
    hs       = sel_ok & ~busy;

    ready      = '0;
    ready[sel] = hs;

    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    locked_d = locked_q;
    if (hs) begin
      grant_d  = sel;
      locked_d = ~sel_last;
      if (sel_last) begin
        rr_ptr_d = (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      locked_q <= locked_d;
    end
  end

  uart_tx_serializer #(
    .CLK_SAMPLES (CLK_SAMPLES)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .load (hs),
    .data (sel_data),
    .tx   (tx),
    .busy (busy)
  );

endmodule
